// File: rtl/core_pkg.sv
// Shared core definitions: sequencer states, PC constants, branch payload and ARM condition codes.
// Build option SEQ_STEP_EN adds the single-step HOLD state.
package core_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned BR_OFS_W  = 24;
  localparam int unsigned WIN_CNT_W = 4;

  localparam logic [XLEN-1:0] PC_STEP     = 32'd4;
  localparam logic [XLEN-1:0] PC_PIPE_OFS = 32'd8;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    WAIT_DEC = 3'd2,
    COMMIT   = 3'd3
`ifdef SEQ_STEP_EN
    ,
    HOLD     = 3'd4
`endif
  } seq_state_e;

  // Branch report captured from the decoder during the evaluation window.
  typedef struct packed {
    logic                cond;
    logic                link;
    logic [BR_OFS_W-1:0] offset;
  } branch_rpt_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Evaluates an ARM condition field against the NZCV flags.
  function automatic logic cond_passed(input cond_e cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch port: request/address out, ready/data back.
interface fetch_sequencer_if;
  import core_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/branch_target_calc.sv
// Combinational branch target (pc + 8 + sext(offset) << 2) and link value (pc + 4).
module branch_target_calc
  import core_pkg::*;
(
  input  logic [XLEN-1:0]     pc,
  input  logic [BR_OFS_W-1:0] offset,
  output logic [XLEN-1:0]     target,
  output logic [XLEN-1:0]     link
);

  localparam int unsigned SEXT_W = XLEN - BR_OFS_W - 2;

  logic [XLEN-1:0] ofs_bytes;

  assign ofs_bytes = {{SEXT_W{offset[BR_OFS_W-1]}}, offset, 2'b00};
  assign target    = pc + PC_PIPE_OFS + ofs_bytes;
  assign link      = pc + PC_STEP;

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end sequencer: fetch, decode pulse, fixed decode window, branch resolve, PC advance.
// Build option SEQ_STEP_EN: adds step_req and a HOLD state gating every fetch.
module fetch_sequencer
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEC_LAT  = 4
) (
  input  logic                clk,
  input  logic                rst,
  fetch_sequencer_if.master   imem,
  output logic [XLEN-1:0]     instr,
  output logic                decode_en,
  input  logic                branch_en,
  input  logic                branch_cond,
  input  logic                branch_link,
  input  logic [BR_OFS_W-1:0] branch_offset,
`ifdef SEQ_STEP_EN
  input  logic                step_req,
`endif
  output logic                lr_we,
  output logic [XLEN-1:0]     lr_wdata,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     retired
);

`ifdef SEQ_STEP_EN
  localparam seq_state_e START_STATE = HOLD;
  localparam seq_state_e POST_COMMIT = HOLD;
`else
  localparam seq_state_e START_STATE = FETCH;
  localparam seq_state_e POST_COMMIT = FETCH;
`endif

  seq_state_e           state_q, state_d;
  logic [WIN_CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic                 br_valid_q, br_valid_d;
  branch_rpt_t          br_q, br_d;
  logic [XLEN-1:0]      instr_d, pc_d, retired_d, lr_wdata_d;
  logic                 decode_en_d, lr_we_d;
  logic [XLEN-1:0]      br_target, br_link_val;

  branch_target_calc u_target (
    .pc     (pc),
    .offset (br_q.offset),
    .target (br_target),
    .link   (br_link_val)
  );

  // Fetch port is a direct decode of the state and PC registers.
  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc;

  // Next-state, datapath and strobe logic.
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    br_valid_d  = br_valid_q;
    br_d        = br_q;
    instr_d     = instr;
    pc_d        = pc;
    retired_d   = retired;
    decode_en_d = 1'b0;
    lr_we_d     = 1'b0;
    lr_wdata_d  = lr_wdata;

    unique case (state_q)
      FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        win_cnt_d  = WIN_CNT_W'(DEC_LAT - 1);
        br_valid_d = 1'b0;
        br_d       = '0;
        state_d    = WAIT_DEC;
      end
      WAIT_DEC: begin
        win_cnt_d = win_cnt_q - WIN_CNT_W'(1);
        // Only the first report of a window counts.
        if (branch_en && !br_valid_q) begin
          br_valid_d = 1'b1;
          br_d       = '{cond: branch_cond, link: branch_link, offset: branch_offset};
        end
        if (win_cnt_q == WIN_CNT_W'(1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        pc_d      = (br_valid_q && br_q.cond) ? br_target : br_link_val;
        retired_d = retired + XLEN'(1);
        state_d   = POST_COMMIT;
      end
`ifdef SEQ_STEP_EN
      HOLD: begin
        if (step_req) begin
          state_d = FETCH;
        end
      end
`endif
      default: begin
        state_d = START_STATE;
      end
    endcase

    // Strobes are registered so they line up with the state they belong to.
    if (state_d == DECODE) begin
      decode_en_d = 1'b1;
    end
    if ((state_d == COMMIT) && br_valid_d && br_d.cond && br_d.link) begin
      lr_we_d    = 1'b1;
      lr_wdata_d = br_link_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= START_STATE;
      win_cnt_q  <= '0;
      br_valid_q <= 1'b0;
      br_q       <= '0;
      instr      <= '0;
      pc         <= RESET_PC;
      retired    <= '0;
      decode_en  <= 1'b0;
      lr_we      <= 1'b0;
      lr_wdata   <= '0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      br_valid_q <= br_valid_d;
      br_q       <= br_d;
      instr      <= instr_d;
      pc         <= pc_d;
      retired    <= retired_d;
      decode_en  <= decode_en_d;
      lr_we      <= lr_we_d;
      lr_wdata   <= lr_wdata_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: vector table of instructions/branches plus reset corner cases.
module tb_fetch_sequencer;
  import core_pkg::*;

  localparam int unsigned DEC_LAT  = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'hE1A0_0000;
`ifdef SEQ_STEP_EN
  localparam logic [31:0] REQ_AFTER_RST = 32'd0;
`else
  localparam logic [31:0] REQ_AFTER_RST = 32'd1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, lr_wdata, pc, retired;
  logic        decode_en, lr_we;
  logic        branch_en, branch_cond, branch_link;
  logic [23:0] branch_offset;
  logic        step_req;

  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(RESET_PC), .DEC_LAT(DEC_LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (bus),
    .instr         (instr),
    .decode_en     (decode_en),
    .branch_en     (branch_en),
    .branch_cond   (branch_cond),
    .branch_link   (branch_link),
    .branch_offset (branch_offset),
`ifdef SEQ_STEP_EN
    .step_req      (step_req),
`endif
    .lr_we         (lr_we),
    .lr_wdata      (lr_wdata),
    .pc            (pc),
    .retired       (retired)
  );

  typedef struct {
    logic [31:0] word;
    int unsigned waits;
    bit          br, cond, link;
    logic [23:0] ofs;
    bit          dbl, pre, stray;
    logic [31:0] exp_pc;
    bit          exp_lr;
    logic [31:0] exp_lr_val;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] lr_val;
    logic [31:0] ret;
    bit          lr;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  vec_t        vecs[10];
  int          checks = 0;
  int          errors = 0;
  int unsigned tick = 0;
  int unsigned tick_rel;
  bit          mon_en = 1'b0;
  bit          lr_seen = 1'b0;
  logic        prev_de = 1'b0;
  logic [31:0] last_ret = '0;
  logic [31:0] model_pc, model_ret, prev_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic chk_true(input string name, input bit cond);
    chk(name, 32'(cond), 32'd1);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    tick++;
  endtask

  function automatic vec_t mk(input logic [31:0] word, input int unsigned waits,
                              input bit br, input bit cond, input bit link, input logic [23:0] ofs,
                              input bit dbl, input bit pre, input bit stray,
                              input logic [31:0] exp_pc, input bit exp_lr, input logic [31:0] exp_lr_val);
    vec_t v;
    v.word = word; v.waits = waits; v.br = br; v.cond = cond; v.link = link; v.ofs = ofs;
    v.dbl = dbl; v.pre = pre; v.stray = stray;
    v.exp_pc = exp_pc; v.exp_lr = exp_lr; v.exp_lr_val = exp_lr_val;
    return v;
  endfunction

  // Output monitor: pops the scoreboard when an instruction retires.
  always @(negedge clk) begin
    if (mon_en) begin
      if (decode_en) begin
        chk("decode_en_single", 32'(prev_de), 32'd0);
        chk_true("decode_sb_nonempty", sb.size() != 0);
        if (sb.size() != 0) chk("decode_instr", instr, sb[0].instr);
      end
      if (lr_we) begin
        chk_true("lr_we_expected", (sb.size() != 0) && sb[0].lr && !lr_seen);
        if (sb.size() != 0) chk("lr_wdata", lr_wdata, sb[0].lr_val);
        lr_seen = 1'b1;
      end
      if (retired != last_ret) begin
        chk_true("retire_sb_nonempty", sb.size() != 0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("commit_pc", pc, e.pc);
          chk("retired_count", retired, e.ret);
          chk("lr_we_seen", 32'(lr_seen), 32'(e.lr));
        end
        lr_seen = 1'b0;
      end
    end
    prev_de  = decode_en;
    last_ret = retired;
  end

  task automatic run_vec(input vec_t v);
    int unsigned t0;
    bit got;
`ifdef SEQ_STEP_EN
    chk("hold_no_req", 32'(bus.imem_req), 32'd0);
    step_req = 1'b1;
    step();
    step_req = 1'b0;
`endif
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.imem_req) got = 1'b1;
      else step();
    end
    chk_true("fetch_req", got);
    chk("fetch_addr", bus.imem_addr, model_pc);
    for (int w = 0; w < int'(v.waits); w++) begin
      if (v.pre && w == 0) begin
        branch_en = 1'b1; branch_cond = 1'b1; branch_link = 1'b1; branch_offset = 24'h000010;
      end
      step();
      branch_en = 1'b0;
      chk("req_held", 32'(bus.imem_req), 32'd1);
      chk("addr_held", bus.imem_addr, model_pc);
      chk("instr_held", instr, prev_instr);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = v.word;
    model_ret = model_ret + 32'd1;
    sb.push_back('{instr: v.word, pc: v.exp_pc, lr_val: v.exp_lr_val, ret: model_ret, lr: v.exp_lr});
    t0 = tick;
    step();
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    chk("decode_en_latency", 32'(decode_en), 32'd1);
    step();
    branch_en = v.br; branch_cond = v.cond; branch_link = v.link; branch_offset = v.ofs;
    step();
    branch_en = v.dbl; branch_cond = 1'b1; branch_link = 1'b1; branch_offset = 24'h000010;
    if (v.stray) begin
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
    end
    step();
    branch_en = 1'b0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (retired == model_ret) got = 1'b1;
      else step();
    end
    chk_true("retire_seen", got);
    chk("retire_latency", tick - t0, DEC_LAT + 2);
    chk("instr_stable", instr, v.word);
    model_pc   = v.exp_pc;
    prev_instr = v.word;
  endtask

  initial begin
    bit lr_fired;
    vecs[0] = mk(NOP,          0, 0, 0, 0, 24'h0,      0, 0, 0, 32'h0000_0004, 0, 32'h0);
    vecs[1] = mk(NOP,          0, 0, 0, 0, 24'h0,      0, 0, 1, 32'h0000_0008, 0, 32'h0);
    vecs[2] = mk(NOP,          0, 0, 0, 0, 24'h0,      0, 0, 0, 32'h0000_000C, 0, 32'h0);
    vecs[3] = mk(32'hEA00003B, 3, 1, 1, 0, 24'h00003B, 0, 0, 0, 32'h0000_0100, 0, 32'h0);
    vecs[4] = mk(32'hEBFFFFFE, 0, 1, 1, 1, 24'hFFFFFE, 0, 0, 0, 32'h0000_0100, 1, 32'h0000_0104);
    vecs[5] = mk(32'h0A000010, 0, 1, 0, 0, 24'h000010, 1, 0, 0, 32'h0000_0104, 0, 32'h0);
    vecs[6] = mk(NOP,          1, 0, 0, 0, 24'h0,      0, 1, 0, 32'h0000_0108, 0, 32'h0);
    vecs[7] = mk(32'hEAFFFFBB, 0, 1, 1, 0, 24'hFFFFBB, 0, 0, 0, 32'hFFFF_FFFC, 0, 32'h0);
    vecs[8] = mk(NOP,          2, 0, 0, 0, 24'h0,      0, 0, 0, 32'h0000_0000, 0, 32'h0);
    vecs[9] = mk(32'hEB000010, 0, 1, 1, 1, 24'h000010, 0, 0, 0, 32'h0000_0048, 1, 32'h0000_0004);

    rst = 1'b1; step_req = 1'b0;
    branch_en = 1'b0; branch_cond = 1'b0; branch_link = 1'b0; branch_offset = '0;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0;
    model_pc = RESET_PC; model_ret = '0; prev_instr = '0;
    step(); step(); step();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_retired", retired, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_decode_en", 32'(decode_en), 32'd0);
    chk("rst_lr_we", 32'(lr_we), 32'd0);
    chk("rst_lr_wdata", lr_wdata, 32'd0);
    chk("rst_imem_req", 32'(bus.imem_req), REQ_AFTER_RST);
    rst = 1'b0;
    tick_rel = tick;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
`ifndef SEQ_STEP_EN
      if (i == 2) begin
        chk("three_retired_cycles", tick - tick_rel, 32'd18);
        chk("three_retired_count", retired, 32'd3);
      end
`endif
    end

    // Reset while inside the decode window, with a BL latched and a stray ready.
    mon_en = 1'b0;
`ifdef SEQ_STEP_EN
    step_req = 1'b1;
    step();
    step_req = 1'b0;
`endif
    chk("midrst_fetch_addr", bus.imem_addr, model_pc);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = NOP;
    step();
    bus.imem_ready = 1'b0;
    step();
    branch_en = 1'b1; branch_cond = 1'b1; branch_link = 1'b1; branch_offset = 24'h000010;
    step();
    rst = 1'b1;
    branch_en = 1'b0;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    step();
    rst = 1'b0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    chk("midrst_pc", pc, RESET_PC);
    chk("midrst_addr", bus.imem_addr, RESET_PC);
    chk("midrst_retired", retired, 32'd0);
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_decode_en", 32'(decode_en), 32'd0);
    chk("midrst_imem_req", 32'(bus.imem_req), REQ_AFTER_RST);
    lr_fired = lr_we;
    for (int i = 0; i < 8; i++) begin
      step();
      if (lr_we) lr_fired = 1'b1;
    end
    chk("midrst_no_lr_we", 32'(lr_fired), 32'd0);
    chk("midrst_pc_idle", pc, RESET_PC);

    sb.delete();
    model_pc = RESET_PC; model_ret = '0; prev_instr = '0;
    mon_en = 1'b1;
    run_vec(mk(NOP, 0, 0, 0, 0, 24'h0, 0, 0, 0, 32'h0000_0004, 0, 32'h0));

    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks %0d)", checks);
    $fatal(1);
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-flow controller that sequences the ARM7 core front end. It owns the PC, fetches one instruction at a time over a ready-handshake instruction-memory port, and hands the word to the decoder with a one-cycle `decode_en` pulse. It then holds off for the decoder's fixed evaluation window, resolves any branch reported by the decoder (target and link value), and advances the PC. It sits between instruction memory and `decoder`, and is the only block that issues `decode_en`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `DEC_LAT`, 4, cycles from the `decode_en` pulse to window close; range 3..15
- `clk` in 1: single core clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `imem_req` out 1: fetch request; held until accepted
- `imem_addr` out 32: fetch address; equals `pc`
- `imem_ready` in 1: memory accepts and returns `imem_rdata` this cycle
- `imem_rdata` in 32: instruction word
- `instr` out 32: latched instruction to decoder
- `decode_en` out 1: one-cycle decode start pulse
- `branch_en` in 1: decoder branch report, sampled only inside the window
- `branch_cond` in 1: branch condition passed
- `branch_link` in 1: BL
- `branch_offset` in 24: signed word offset
- `lr_we` out 1: one-cycle link-register write strobe
- `lr_wdata` out 32: link value
- `pc` out 32: address of the current/next fetch
- `retired` out 32: count of completed instructions
- `step_req` in 1: present only with `SEQ_STEP_EN`

## Operation
- States: `FETCH`, `DECODE`, `WAIT_DEC`, `COMMIT`, and `HOLD` (`HOLD` only with the macro).
- `FETCH`: `imem_req`=1, `imem_addr`=`pc`. On `imem_ready`, latch `imem_rdata` into `instr` and go to `DECODE`.
- `DECODE`: `decode_en`=1 for exactly this cycle. Load the window counter with `DEC_LAT`-1. Go to `WAIT_DEC`.
- `WAIT_DEC`: decrement the counter each cycle. The first `branch_en`=1 seen latches cond, link and offset; later pulses in the same window are ignored. At counter 0, go to `COMMIT`.
- `COMMIT`, one cycle:
  - If a branch was latched with cond=1: `pc` ← `pc` + 8 + (sext(`branch_offset`) << 2).
  - If a branch was latched with cond=1 and link=1: also `lr_we`=1, `lr_wdata` = `pc` + 4.
  - Otherwise (no branch, or cond=0): `pc` ← `pc` + 4.
  - `retired` += 1. Then go to `FETCH`.
- Arithmetic: all 32-bit, modulo 2^32; the PC wraps 0xFFFF_FFFC → 0.
- `branch_en` outside `WAIT_DEC` is ignored.
- Reset values:
  - `pc`=`RESET_PC`, state=`FETCH`, `retired`=0, `instr`=0.
  - `imem_req`, `decode_en`, `lr_we`, `lr_wdata` = 0.
  - Latched branch flags cleared.

## Timing
- Fetch latency: 1 cycle plus memory wait states. `imem_addr` is stable while `imem_req` is high.
- Per-instruction minimum, zero-wait memory: 1 (`FETCH`) + 1 (`DECODE`) + `DEC_LAT`-1 (`WAIT_DEC`) + 1 (`COMMIT`) = `DEC_LAT`+2 cycles (6 at default).
- `instr` is stable from `DECODE` through `COMMIT`.
- `pc` updates on the clock edge that leaves `COMMIT`. The next `imem_req` is issued in the following cycle with the new address.
- Reset mid-operation, any state: the next cycle is `FETCH` at `RESET_PC` with all strobes low. An in-flight `imem_ready` in the reset cycle is discarded.
- `imem_ready` asserted while `imem_req`=0 is ignored.

## Configuration
- `SEQ_STEP_EN` defined:
  - `step_req` port exists; `COMMIT` goes to `HOLD` instead of `FETCH`.
  - `HOLD` waits for `step_req`=1, then goes to `FETCH`. After reset, the first fetch also waits in `HOLD`.
- `SEQ_STEP_EN` undefined:
  - No `step_req` port and no `HOLD` state; runs continuously from reset.

## Structure
- Shared package `core_pkg`:
  - state enumeration;
  - `PC_STEP`=4, `PC_PIPE_OFS`=8;
  - the condition-code constants already shared with `decoder`.
- Sub-module `branch_target_calc`: combinational; inputs `pc` and offset; outputs target and link value. Reused by later execute-stage logic.

## Test plan
- Reset, zero-wait memory returning 0xE1A00000 (NOP): `pc` steps 0,4,8 every 6 cycles; `decode_en` is a one-cycle pulse; `retired`=3 after 18 cycles.
- `imem_ready` delayed 3 cycles: `imem_req`/`imem_addr` held stable; `instr` latched only on the ready cycle.
- At `pc`=0x100, `branch_en`=1, cond=1, link=1, offset=0xFFFFFE in `WAIT_DEC`: next `pc`=0x100; `lr_we` pulses once with 0x104.
- Branch with cond=0, offset=0x000010: `pc`=old+4, no `lr_we`. A second `branch_en` in the same window is ignored. `branch_en` during `FETCH` has no effect.
- `pc`=0xFFFF_FFFC with no branch → `pc`=0. `rst` asserted during `WAIT_DEC` → `pc`=`RESET_PC`, `retired`=0, no `lr_we`.
- With `SEQ_STEP_EN`: no `imem_req` until a `step_req` pulse; exactly one instruction retires per pulse.
